ctrl_issue_unit: RTL and testbench
==================================

// Module: ctrl_issue_unit
// PURPOSE
//  Registered, handshaked successor to the ID-stage control decoder. Decodes opcode/funct fields
//  into the ID/EX control bundle, adds RV32M mul/div detection, and holds issue for a
//  parametrised number of cycles on multi-cycle ops. Supports valid/ready flow, flush-to-bubble
//  and illegal-op flagging. Sits between the IF/ID register and the ID/EX register.
// PARAMETERS
//  MULDIV_EN  1  1: decode OP_REG with funct7=7'b0000001 as mul/div; 0: treat as plain R-type
//  MUL_LAT    3  EX cycles of a mul (funct3[2]=0), range 1..15
//  DIV_LAT    8  EX cycles of a div/rem (funct3[2]=1), range 1..15
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  asynchronous reset, active-low
//  in_valid    in   1  instruction fields valid
//  in_ready    out  1  unit accepts fields this cycle
//  opcode      in   7  instruction[6:0]
//  funct3      in   3  instruction[14:12]
//  funct7      in   7  instruction[31:25]
//  flush       in   1  from HazardDetection: kill held bundle, abort mul/div wait
//  out_valid   out  1  control bundle valid
//  out_ready   in   1  ID/EX accepts bundle
//  alusrc, memtoreg, regwrite, memread, memwrite, branch  out 1 each  registered controls
//  aluop       out  2  ALU op class
//  aluinputpc  out  1  auipc: PC as ALU input 1
//  branchjalx  out  1  jal/jalr: write PC+4, force pcsrc
//  alu2pc      out  1  jalr: ALU result to PC
//  muldiv      out  1  mul/div op (MULDIV_EN=1 only)
//  illegal     out  1  opcode[1:0]!=2'b11 or unknown opcode[6:2]
//  md_busy     out  1  high while in MD_WAIT
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, state IDLE, counter 0. in_ready=0 during reset.
//  - Decode {alusrc,memtoreg,regwrite,memread,memwrite,branch,aluop} on opcode[6:2]:
//    OP_REG 00100010, OP_JALR 10100001, OP_IMML 11110000, OP_IMMOP 10100011, OP_STORE 10001000,
//    OP_BRANCH 00000101, OP_LUI 10100000, OP_AUIPC 10100000, OP_JAL 00100100, other 00000000.
//    aluinputpc=AUIPC; branchjalx=JAL|JALR; alu2pc=JALR. Illegal: all controls 0, illegal=1.
//  - in_ready = rst & ~flush & (state==IDLE) & (~out_valid | out_ready).
//  - Accept (in_valid & in_ready): decoded bundle registered; out_valid=1 next cycle (latency 1).
//  - out_valid & out_ready with no accept: out_valid->0 and all control outputs -> 0 (bubble).
//  - Control outputs are 0 whenever out_valid=0; never stale.
//  - Flush (priority over everything): next cycle out_valid=0, bundle 0, state IDLE, counter 0.
//  - FSM IDLE -> MD_WAIT on accepting a mul/div whose latency L>1; counter loads L-1.
//    MD_WAIT: counter decrements each cycle, md_busy=1, in_ready=0; at counter==1 -> IDLE
//    next edge. L=1: stays IDLE, no stall.
//  - The mul/div bundle is presented on the cycle after accept, like any op; the stall only blocks
//    following instructions.
//  - Counter width 4 bits; no wrap: decrement only while nonzero.
//  - Handshake: out_valid held with bundle unchanged until out_ready or flush.
//  - MULDIV_EN=0: muldiv=0 always, no MD_WAIT entry, funct7 ignored.
// TESTING
//  - Reset mid-op: assert rst=0 during MD_WAIT -> all outputs 0 same cycle, in_ready=1 after release.
//  - lw (opcode 0000011), out_ready=1 -> next cycle alusrc=memtoreg=regwrite=memread=1, aluop=00.
//  - mul (0110011, funct7=0000001, f3=000), MUL_LAT=3 -> bundle with muldiv=1 at T+1;
//    md_busy=1 at T+1..T+2; in_ready=1 at T+3.
//  - div, DIV_LAT=8, flush at 3rd wait cycle -> out_valid=0, md_busy=0, in_ready=1 next cycle.
//  - jalr with out_ready=0 for 4 cycles -> alusrc,regwrite,branchjalx,alu2pc=1, aluop=01 held;
//    in_ready=0; released on ready.
//  - opcode 7'b1111100 / opcode[1:0]=00 -> illegal=1, all other controls 0, out_valid=1.

Source files
------------

// File: rtl/ctrl_issue_if.sv
// Handshake and control-bundle bus between the IF/ID side, the issue unit and the ID/EX register.
// The issue unit takes the slave view; the upstream/downstream environment takes the master view.
interface ctrl_issue_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       aluinputpc;
    logic       branchjalx;
    logic       alu2pc;
    logic       muldiv;
    logic       illegal;
    logic       md_busy;

    modport slave (
        input  in_valid, opcode, funct3, funct7, flush, out_ready,
        output in_ready, out_valid, alusrc, memtoreg, regwrite, memread, memwrite, branch,
               aluop, aluinputpc, branchjalx, alu2pc, muldiv, illegal, md_busy
    );

    modport master (
        output in_valid, opcode, funct3, funct7, flush, out_ready,
        input  in_ready, out_valid, alusrc, memtoreg, regwrite, memread, memwrite, branch,
               aluop, aluinputpc, branchjalx, alu2pc, muldiv, illegal, md_busy
    );
endinterface

// File: rtl/ctrl_issue_unit.sv
// Registered ID-stage control decoder with valid/ready flow, flush-to-bubble, illegal-op
// flagging and an issue stall that covers the EX latency of RV32M mul/div operations.
module ctrl_issue_unit #(
    parameter bit          MULDIV_EN = 1'b1,
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned DIV_LAT   = 8
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_issue_if.slave  bus
);

    localparam logic [4:0] OP_IMML   = 5'b00000;
    localparam logic [4:0] OP_IMMOP  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [3:0] MUL_LAT4 = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT4 = 4'(DIV_LAT);

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic       aluinputpc;
        logic       branchjalx;
        logic       alu2pc;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, MD_WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    ctrl_t      bundle_q, bundle_d;
    ctrl_t      dec;
    logic [3:0] lat_sel;
    logic       accept;

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        dec = '0;
        if (bus.opcode[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            unique case (bus.opcode[6:2])
                OP_REG: begin
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b00100010;
                    dec.muldiv = MULDIV_EN && (bus.funct7 == 7'b0000001);
                end
                OP_JALR: begin
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b10100001;
                    dec.branchjalx = 1'b1;
                    dec.alu2pc     = 1'b1;
                end
                OP_IMML:
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b11110000;
                OP_IMMOP:
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b10100011;
                OP_STORE:
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b10001000;
                OP_BRANCH:
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b00000101;
                OP_LUI:
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b10100000;
                OP_AUIPC: begin
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b10100000;
                    dec.aluinputpc = 1'b1;
                end
                OP_JAL: begin
                    {dec.alusrc, dec.memtoreg, dec.regwrite, dec.memread,
                     dec.memwrite, dec.branch, dec.aluop} = 8'b00100100;
                    dec.branchjalx = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // funct3[2] separates div/rem from mul within the RV32M group.
    assign lat_sel = bus.funct3[2] ? DIV_LAT4 : MUL_LAT4;

    assign bus.in_ready = rst & ~bus.flush & (state_q == IDLE) & (~valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        bundle_d = bundle_q;

        if (bus.flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            bundle_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && dec.muldiv && (lat_sel > 4'd1)) begin
                        state_d = MD_WAIT;
                        cnt_d   = lat_sel - 4'd1;
                    end
                end
                MD_WAIT: begin
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                    // A zero count cannot normally occur here; leaving on it avoids a dead state.
                    if (cnt_q <= 4'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (accept) begin
                valid_d  = 1'b1;
                bundle_d = dec;
            end else if (valid_q && bus.out_ready) begin
                valid_d  = 1'b0;
                bundle_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.alusrc     = bundle_q.alusrc;
    assign bus.memtoreg   = bundle_q.memtoreg;
    assign bus.regwrite   = bundle_q.regwrite;
    assign bus.memread    = bundle_q.memread;
    assign bus.memwrite   = bundle_q.memwrite;
    assign bus.branch     = bundle_q.branch;
    assign bus.aluop      = bundle_q.aluop;
    assign bus.aluinputpc = bundle_q.aluinputpc;
    assign bus.branchjalx = bundle_q.branchjalx;
    assign bus.alu2pc     = bundle_q.alu2pc;
    assign bus.muldiv     = bundle_q.muldiv;
    assign bus.illegal    = bundle_q.illegal;
    assign bus.md_busy    = (state_q == MD_WAIT);

endmodule

// File: tb/tb_ctrl_issue_unit.sv
// Directed bench for ctrl_issue_unit: a mul/div-enabled instance plus a MULDIV_EN=0 instance
// fed the same inputs. Bundle vectors are {alusrc,memtoreg,regwrite,memread,memwrite,branch,
// aluop,aluinputpc,branchjalx,alu2pc,muldiv,illegal}.
module tb_ctrl_issue_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ctrl_issue_if bus ();
    ctrl_issue_if bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.opcode    = bus.opcode;
    assign bus2.funct3    = bus.funct3;
    assign bus2.funct7    = bus.funct7;
    assign bus2.flush     = bus.flush;
    assign bus2.out_ready = bus.out_ready;

    ctrl_issue_unit #(.MULDIV_EN(1'b1), .MUL_LAT(3), .DIV_LAT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ctrl_issue_unit #(.MULDIV_EN(1'b0), .MUL_LAT(3), .DIV_LAT(8)) dut_nomd (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] bundle1();
        return {bus.alusrc, bus.memtoreg, bus.regwrite, bus.memread, bus.memwrite, bus.branch,
                bus.aluop, bus.aluinputpc, bus.branchjalx, bus.alu2pc, bus.muldiv, bus.illegal};
    endfunction

    function automatic logic [12:0] bundle2();
        return {bus2.alusrc, bus2.memtoreg, bus2.regwrite, bus2.memread, bus2.memwrite, bus2.branch,
                bus2.aluop, bus2.aluinputpc, bus2.branchjalx, bus2.alu2pc, bus2.muldiv, bus2.illegal};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [12:0] B_LW    = 13'b11110000_00000;
    localparam logic [12:0] B_MUL   = 13'b00100010_00010;
    localparam logic [12:0] B_RTYPE = 13'b00100010_00000;
    localparam logic [12:0] B_JALR  = 13'b10100001_01100;
    localparam logic [12:0] B_ILL   = 13'b00000000_00001;

    logic [6:0]  tab_op  [6] = '{7'b0010111, 7'b1101111, 7'b0100011,
                                 7'b1100011, 7'b0010011, 7'b0110111};
    logic [12:0] tab_exp [6] = '{13'b10100000_10000, 13'b00100100_01000, 13'b10001000_00000,
                                 13'b00000101_00000, 13'b10100011_00000, 13'b10100000_00000};

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("rst_bundle", 16'(bundle1()), 16'd0);
        check("rst_md_busy", 16'(bus.md_busy), 16'd0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 16'(bus.in_ready), 16'd1);

        // lw, then bubble
        bus.in_valid = 1'b1;
        bus.opcode   = 7'b0000011;
        tick();
        bus.in_valid = 1'b0;
        check("lw_out_valid", 16'(bus.out_valid), 16'd1);
        check("lw_bundle", 16'(bundle1()), 16'(B_LW));
        tick();
        check("bubble_out_valid", 16'(bus.out_valid), 16'd0);
        check("bubble_bundle", 16'(bundle1()), 16'd0);

        // mul, MUL_LAT=3
        bus.in_valid = 1'b1;
        bus.opcode   = 7'b0110011;
        bus.funct7   = 7'b0000001;
        bus.funct3   = 3'b000;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("mul_t1_bundle", 16'(bundle1()), 16'(B_MUL));
        check("mul_t1_out_valid", 16'(bus.out_valid), 16'd1);
        check("mul_t1_md_busy", 16'(bus.md_busy), 16'd1);
        check("mul_t1_in_ready", 16'(bus.in_ready), 16'd0);
        check("nomd_bundle", 16'(bundle2()), 16'(B_RTYPE));
        check("nomd_md_busy", 16'(bus2.md_busy), 16'd0);
        check("nomd_in_ready", 16'(bus2.in_ready), 16'd1);
        tick();
        check("mul_t2_md_busy", 16'(bus.md_busy), 16'd1);
        check("mul_t2_in_ready", 16'(bus.in_ready), 16'd0);
        check("mul_t2_out_valid", 16'(bus.out_valid), 16'd0);
        tick();
        check("mul_t3_md_busy", 16'(bus.md_busy), 16'd0);
        check("mul_t3_in_ready", 16'(bus.in_ready), 16'd1);

        // div, DIV_LAT=8, bundle held, flush on third wait cycle
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.funct3    = 3'b100;
        tick();
        bus.in_valid = 1'b0;
        check("div_w1_out_valid", 16'(bus.out_valid), 16'd1);
        check("div_w1_md_busy", 16'(bus.md_busy), 16'd1);
        check("div_w1_bundle", 16'(bundle1()), 16'(B_MUL));
        tick();
        tick();
        check("div_w3_held", 16'(bus.out_valid), 16'd1);
        check("div_w3_md_busy", 16'(bus.md_busy), 16'd1);
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready", 16'(bus.in_ready), 16'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush_out_valid", 16'(bus.out_valid), 16'd0);
        check("flush_md_busy", 16'(bus.md_busy), 16'd0);
        check("flush_in_ready_after", 16'(bus.in_ready), 16'd1);
        check("flush_bundle", 16'(bundle1()), 16'd0);

        // jalr held for 4 cycles under backpressure
        bus.in_valid = 1'b1;
        bus.opcode   = 7'b1100111;
        bus.funct7   = 7'b0000000;
        bus.funct3   = 3'b000;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("jalr_hold%0d_bundle", i), 16'(bundle1()), 16'(B_JALR));
            check($sformatf("jalr_hold%0d_in_ready", i), 16'(bus.in_ready), 16'd0);
            tick();
        end
        check("jalr_still_valid", 16'(bus.out_valid), 16'd1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = 7'b1111100;
        #1;
        check("jalr_release_in_ready", 16'(bus.in_ready), 16'd1);
        tick();
        check("ill_1111100_valid", 16'(bus.out_valid), 16'd1);
        check("ill_1111100_bundle", 16'(bundle1()), 16'(B_ILL));
        bus.opcode = 7'b0110000;
        tick();
        check("ill_low00_valid", 16'(bus.out_valid), 16'd1);
        check("ill_low00_bundle", 16'(bundle1()), 16'(B_ILL));

        // Back-to-back decode table
        for (int i = 0; i < 6; i++) begin
            bus.opcode = tab_op[i];
            tick();
            check($sformatf("tab%0d_bundle", i), 16'(bundle1()), 16'(tab_exp[i]));
        end
        bus.in_valid = 1'b0;
        tick();
        check("tab_drain_valid", 16'(bus.out_valid), 16'd0);

        // Reset in the middle of a mul wait
        bus.in_valid = 1'b1;
        bus.opcode   = 7'b0110011;
        bus.funct7   = 7'b0000001;
        bus.funct3   = 3'b000;
        tick();
        bus.in_valid = 1'b0;
        check("rmid_md_busy_before", 16'(bus.md_busy), 16'd1);
        rst = 1'b0;
        #1;
        check("rmid_out_valid", 16'(bus.out_valid), 16'd0);
        check("rmid_md_busy", 16'(bus.md_busy), 16'd0);
        check("rmid_in_ready", 16'(bus.in_ready), 16'd0);
        check("rmid_bundle", 16'(bundle1()), 16'd0);
        tick();
        rst = 1'b1;
        #1;
        check("rmid_release_in_ready", 16'(bus.in_ready), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
